// File: rtl/gb_cpu_irq_ctrl.sv
// GameBoy CPU interrupt controller: IF/IE registers, IME with EI delay, and the 5-M-cycle dispatch sequencer.
// Optional HALT-bug detection is built when GB_IRQ_HALT_BUG_EN is defined.
module gb_cpu_irq_ctrl #(
    parameter int          NUM_IRQ     = 5,
    parameter logic [7:0]  VECTOR_BASE = 8'h40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m_tick,
    input  logic               instr_boundary,
    input  logic               ei,
    input  logic               di,
    input  logic               reti,
    input  logic               halt_enter,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [15:0]        bus_addr,
    input  logic [7:0]         bus_wdata,
    input  logic               bus_wren,
    output logic [7:0]         bus_rdata,
    output logic               irq_pending,
    output logic               wake,
    output logic               dispatch_active,
    output logic [2:0]         dispatch_cycle,
    output logic               vector_valid,
    output logic [7:0]         vector,
    output logic               halt_bug
);

    typedef enum logic {IDLE = 1'b0, DISPATCH = 1'b1} state_t;

    state_t             state_r, state_n;
    logic [NUM_IRQ-1:0] if_r, if_n, ie_r, masked_s;
    logic               ime_r, ime_n, arm1_r, arm1_n, arm2_r, arm2_n, arm1_eff_s;
    logic               start_s, sample_s, hit_s;
    logic [2:0]         cyc_r, idx_s;
    logic [7:0]         vector_r;
    logic               valid_r;

    function automatic logic [2:0] lowest_idx(input logic [NUM_IRQ-1:0] req);
        lowest_idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) lowest_idx = 3'(i);
        end
    endfunction

    assign masked_s = ie_r & if_r;
    assign hit_s    = |masked_s;
    assign idx_s    = lowest_idx(masked_s);
    assign sample_s = m_tick && (state_r == DISPATCH) && (cyc_r == 3'd3);

    // IME / EI-arm next state and dispatch start decision (uses the freshly updated IME)
    always_comb begin
        ime_n      = ime_r;
        arm1_n     = arm1_r;
        arm2_n     = arm2_r;
        arm1_eff_s = arm1_r;
        start_s    = 1'b0;
        if (m_tick && (state_r == IDLE)) begin
            if (di) begin
                ime_n  = 1'b0;
                arm1_n = 1'b0;
                arm2_n = 1'b0;
            end else begin
                arm1_eff_s = arm1_r | (ei & ~ime_r);
                ime_n      = ime_r | reti;
                if (instr_boundary) begin
                    ime_n  = ime_n | arm2_r;
                    arm2_n = arm1_eff_s;
                    arm1_n = 1'b0;
                end else begin
                    arm1_n = arm1_eff_s;
                end
            end
            start_s = instr_boundary & ime_n & hit_s & ~halt_enter;
            if (start_s) begin
                ime_n  = 1'b0;
                arm1_n = 1'b0;
                arm2_n = 1'b0;
            end else begin
                ime_n  = ime_n;
            end
        end else begin
            start_s = 1'b0;
        end
    end

    // IF next value: CPU write, then dispatch clear, then source pulses OR'd in last
    always_comb begin
        if_n = if_r;
        if (bus_wren && (bus_addr == 16'hFF0F)) begin
            if_n = bus_wdata[NUM_IRQ-1:0];
        end else begin
            if_n = if_r;
        end
        if (sample_s && hit_s) begin
            if_n[idx_s] = 1'b0;
        end else begin
            if_n = if_n;
        end
        if_n = if_n | irq_src;
    end

    // FSM next state
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:     state_n = start_s ? DISPATCH : IDLE;
            DISPATCH: state_n = (m_tick && (cyc_r == 3'd4)) ? IDLE : DISPATCH;
            default:  state_n = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_n;
    end

    // Interrupt registers and IME/arm state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_r   <= '0;
            ie_r   <= '0;
            ime_r  <= 1'b0;
            arm1_r <= 1'b0;
            arm2_r <= 1'b0;
        end else begin
            if_r   <= if_n;
            ime_r  <= ime_n;
            arm1_r <= arm1_n;
            arm2_r <= arm2_n;
            if (bus_wren && (bus_addr == 16'hFFFF)) ie_r <= bus_wdata[NUM_IRQ-1:0];
            else                                    ie_r <= ie_r;
        end
    end

    // Dispatch cycle counter and vector latch; IE&IF re-sampled on the 3->4 step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_r    <= 3'd0;
            vector_r <= 8'h00;
            valid_r  <= 1'b0;
        end else if (m_tick && (state_r == DISPATCH)) begin
            case (cyc_r)
                3'd3: begin
                    cyc_r    <= 3'd4;
                    valid_r  <= 1'b1;
                    vector_r <= hit_s ? (VECTOR_BASE + {2'b00, idx_s, 3'b000}) : 8'h00;
                end
                3'd4: begin
                    cyc_r    <= 3'd0;
                    valid_r  <= 1'b0;
                    vector_r <= 8'h00;
                end
                default: cyc_r <= cyc_r + 3'd1;
            endcase
        end else begin
            cyc_r <= cyc_r;
        end
    end

`ifdef GB_IRQ_HALT_BUG_EN
    logic halt_bug_r;
    // HALT entered with IME clear while an enabled request is already pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) halt_bug_r <= 1'b0;
        else       halt_bug_r <= m_tick & halt_enter & ~ime_r & hit_s;
    end
    assign halt_bug = halt_bug_r;
`else
    assign halt_bug = 1'b0;
`endif

    // Outputs and combinational register read mux
    always_comb begin
        irq_pending     = ime_r & hit_s;
        wake            = hit_s;
        dispatch_active = (state_r == DISPATCH);
        dispatch_cycle  = cyc_r;
        vector_valid    = valid_r;
        vector          = vector_r;
        bus_rdata       = 8'h00;
        case (bus_addr)
            16'hFF0F: begin
                bus_rdata              = 8'hFF;
                bus_rdata[NUM_IRQ-1:0] = if_r;
            end
            16'hFFFF: bus_rdata[NUM_IRQ-1:0] = ie_r;
            default:  bus_rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_gb_cpu_irq_ctrl.sv
// Directed testbench for gb_cpu_irq_ctrl: reset, dispatch, EI delay, DI cancel, late IE change, IF precedence, HALT.
module tb_gb_cpu_irq_ctrl;
    logic       clk = 1'b0, reset = 1'b1, m_tick = 1'b0, instr_boundary = 1'b0;
    logic       ei = 1'b0, di = 1'b0, reti = 1'b0, halt_enter = 1'b0, bus_wren = 1'b0;
    logic [4:0] irq_src = 5'd0;
    logic [15:0] bus_addr = 16'h0000;
    logic [7:0] bus_wdata = 8'h00, bus_rdata, vector;
    logic       irq_pending, wake, dispatch_active, vector_valid, halt_bug;
    logic [2:0] dispatch_cycle;
    int total = 0, bad = 0;

`ifdef GB_IRQ_HALT_BUG_EN
    localparam logic HB_EXP = 1'b1;
`else
    localparam logic HB_EXP = 1'b0;
`endif

    gb_cpu_irq_ctrl dut (
        .clk(clk), .reset(reset), .m_tick(m_tick), .instr_boundary(instr_boundary),
        .ei(ei), .di(di), .reti(reti), .halt_enter(halt_enter), .irq_src(irq_src),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wren(bus_wren), .bus_rdata(bus_rdata),
        .irq_pending(irq_pending), .wake(wake), .dispatch_active(dispatch_active),
        .dispatch_cycle(dispatch_cycle), .vector_valid(vector_valid), .vector(vector),
        .halt_bug(halt_bug)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic ib, input logic e, input logic d, input logic r, input logic h);
        @(negedge clk);
        m_tick = 1'b1; instr_boundary = ib; ei = e; di = d; reti = r; halt_enter = h;
        @(posedge clk); #1;
        m_tick = 1'b0; instr_boundary = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0; halt_enter = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a; bus_wdata = d; bus_wren = 1'b1;
        @(posedge clk); #1;
        bus_wren = 1'b0; bus_addr = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a);
        bus_addr = a; #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        rd(16'hFF0F);
        total++; if (bus_rdata !== 8'hE0) begin bad++; $display("FAIL rst_if got=%h exp=%h", bus_rdata, 8'hE0); end
        rd(16'hFFFF);
        total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL rst_ie got=%h exp=%h", bus_rdata, 8'h00); end
        total++; if ({irq_pending, wake, dispatch_active, dispatch_cycle, vector_valid, vector, halt_bug} !== 15'd0) begin
            bad++; $display("FAIL rst_outs got=%b exp=0", {irq_pending, wake, dispatch_active, dispatch_cycle, vector_valid, vector, halt_bug});
        end
    endtask

    task automatic test_dispatch_basic;
        wr(16'hFFFF, 8'h05);
        wr(16'hFF0F, 8'h04);
        total++; if (wake !== 1'b1 || irq_pending !== 1'b0) begin bad++; $display("FAIL basic_pre got=%b%b exp=10", wake, irq_pending); end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (irq_pending !== 1'b1) begin bad++; $display("FAIL basic_reti got=%b exp=1", irq_pending); end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (dispatch_active !== 1'b1 || dispatch_cycle !== 3'd0) begin
            bad++; $display("FAIL basic_start got=%b/%0d exp=1/0", dispatch_active, dispatch_cycle);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            total++; if (dispatch_active !== 1'b1 || dispatch_cycle !== 3'(k) || vector_valid !== (k == 4)) begin
                bad++; $display("FAIL basic_cyc%0d got=%b/%0d/%b exp=1/%0d/%b", k, dispatch_active, dispatch_cycle, vector_valid, k, k == 4);
            end
        end
        total++; if (vector !== 8'h50) begin bad++; $display("FAIL basic_vec got=%h exp=%h", vector, 8'h50); end
        rd(16'hFF0F);
        total++; if (bus_rdata !== 8'hE0) begin bad++; $display("FAIL basic_ifclr got=%h exp=%h", bus_rdata, 8'hE0); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (dispatch_active !== 1'b0 || dispatch_cycle !== 3'd0 || vector !== 8'h00 || vector_valid !== 1'b0) begin
            bad++; $display("FAIL basic_end got=%b/%0d/%h exp=0/0/00", dispatch_active, dispatch_cycle, vector);
        end
    endtask

    task automatic test_ei_delay;
        wr(16'hFFFF, 8'h01);
        wr(16'hFF0F, 8'h01);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (dispatch_active !== 1'b0 || irq_pending !== 1'b0) begin bad++; $display("FAIL ei_a got=%b%b exp=00", dispatch_active, irq_pending); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (dispatch_active !== 1'b0) begin bad++; $display("FAIL ei_mid got=%b exp=0", dispatch_active); end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (dispatch_active !== 1'b1 || irq_pending !== 1'b0) begin bad++; $display("FAIL ei_b got=%b%b exp=10", dispatch_active, irq_pending); end
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (vector !== 8'h40 || vector_valid !== 1'b1) begin bad++; $display("FAIL ei_vec got=%h exp=%h", vector, 8'h40); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ei_di;
        wr(16'hFF0F, 8'h01);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            total++; if (dispatch_active !== 1'b0 || irq_pending !== 1'b0 || wake !== 1'b1) begin
                bad++; $display("FAIL eidi_b%0d got=%b%b%b exp=001", k, dispatch_active, irq_pending, wake);
            end
        end
    endtask

    task automatic test_late_ie;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (dispatch_cycle !== 3'd3) begin bad++; $display("FAIL cancel_c3 got=%0d exp=3", dispatch_cycle); end
        wr(16'hFFFF, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (vector !== 8'h00 || vector_valid !== 1'b1) begin bad++; $display("FAIL cancel_vec got=%h/%b exp=00/1", vector, vector_valid); end
        rd(16'hFF0F);
        total++; if (bus_rdata !== 8'hE1) begin bad++; $display("FAIL cancel_if got=%h exp=%h", bus_rdata, 8'hE1); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wr(16'hFFFF, 8'h03);
        wr(16'hFF0F, 8'h03);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wr(16'hFFFF, 8'h02);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (vector !== 8'h48) begin bad++; $display("FAIL late_vec got=%h exp=%h", vector, 8'h48); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd(16'hFF0F);
        total++; if (bus_rdata !== 8'hE1) begin bad++; $display("FAIL late_if got=%h exp=%h", bus_rdata, 8'hE1); end
        rd(16'hFFFF);
        total++; if (bus_rdata !== 8'h02) begin bad++; $display("FAIL late_ie got=%h exp=%h", bus_rdata, 8'h02); end
    endtask

    task automatic test_if_precedence;
        @(negedge clk);
        bus_addr = 16'hFF0F; bus_wdata = 8'h00; bus_wren = 1'b1; irq_src = 5'b00010;
        @(posedge clk); #1;
        bus_wren = 1'b0; irq_src = 5'b00000;
        rd(16'hFF0F);
        total++; if (bus_rdata !== 8'hE2) begin bad++; $display("FAIL prec_if got=%h exp=%h", bus_rdata, 8'hE2); end
        bus_addr = 16'h0000;
    endtask

    task automatic test_halt;
        total++; if (wake !== 1'b1 || irq_pending !== 1'b0) begin bad++; $display("FAIL halt_wake got=%b%b exp=10", wake, irq_pending); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (halt_bug !== HB_EXP) begin bad++; $display("FAIL halt_bug got=%b exp=%b", halt_bug, HB_EXP); end
        @(posedge clk); #1;
        total++; if (halt_bug !== 1'b0) begin bad++; $display("FAIL halt_bug_pulse got=%b exp=0", halt_bug); end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (dispatch_active !== 1'b0 || halt_bug !== 1'b0) begin bad++; $display("FAIL halt_nodisp got=%b%b exp=00", dispatch_active, halt_bug); end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (dispatch_active !== 1'b1) begin bad++; $display("FAIL halt_disp got=%b exp=1", dispatch_active); end
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (vector !== 8'h48 || wake !== 1'b0) begin bad++; $display("FAIL halt_vec got=%h/%b exp=48/0", vector, wake); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (dispatch_active !== 1'b0) begin bad++; $display("FAIL halt_end got=%b exp=0", dispatch_active); end
    endtask

    initial begin
        test_reset();
        test_dispatch_basic();
        test_ei_delay();
        test_ei_di();
        test_late_ie();
        test_if_precedence();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gb_cpu_irq_ctrl.md
Name: gb_cpu_irq_ctrl

Overview:
Interrupt controller for the GameBoy CPU core. It sits directly upstream of the decoder/scheduler and owns the IF (0xFF0F) and IE (0xFFFF) registers and the IME flag. It executes the control signals enable_interrupts / disable_interrupts, including the one-instruction EI delay. It drives the 5-M-cycle interrupt dispatch sequence that the scheduler turns into PC push and jump control_signals_t entries.

Parameters:
NUM_IRQ, 5, number of interrupt sources. Bit 0 = VBlank (highest priority) through bit 4 = Joypad.
VECTOR_BASE, 8'h40, vector of source 0. Source n vector = VECTOR_BASE + 8*n.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_tick  in  1  one-clk pulse marking the end of each M-cycle; all FSM/IME state advances only on clk edges with m_tick=1
instr_boundary  in  1  high during the final M-cycle of the current instruction (next M-cycle is an opcode fetch)
ei  in  1  control signal enable_interrupts (EI executing), sampled with m_tick
di  in  1  control signal disable_interrupts (DI), sampled with m_tick
reti  in  1  RETI executing, sampled with m_tick
halt_enter  in  1  HALT executing, sampled with m_tick
irq_src  in  NUM_IRQ  peripheral request pulses, sampled every clk
bus_addr  in  16  CPU address bus
bus_wdata  in  8  CPU write data
bus_wren  in  1  CPU write strobe, sampled every clk
bus_rdata  out  8  combinational read data for 0xFF0F/0xFFFF, else 8'h00
irq_pending  out  1  IME & |(IE & IF)
wake  out  1  |(IE & IF) regardless of IME (HALT exit)
dispatch_active  out  1  dispatch sequence in progress
dispatch_cycle  out  3  dispatch M-cycle index 0..4; 0 when idle
vector_valid  out  1  high during dispatch_cycle 4
vector  out  8  jump target low byte; PC high byte = 0x00
halt_bug  out  1  see Optional Feature

Behaviour:
- Reset: IF=0, IE=0, IME=0, EI arm state cleared, FSM IDLE. All outputs 0 except bus_rdata, which is combinational.
- Register reads:
  - 0xFF0F returns {3'b111, IF}.
  - 0xFFFF returns {3'b000, IE}.
- Register writes:
  - Writes to 0xFF0F and 0xFFFF take effect on the same clk edge.
  - Upper bits written to 0xFF0F are discarded; IE stores only its low 5 bits.
- IF update precedence per clk, applied in order: (1) CPU write, (2) dispatch clear, (3) OR with irq_src. A source pulse therefore always wins.
- IME/EI state, one m_tick at a time:
  - ei sets ARM1.
  - On an instr_boundary m_tick: ARM1 becomes ARM2; ARM2 sets IME=1 and clears ARM2.
  - Effect: IME rises at the end of the instruction after EI.
  - The dispatch decision on that same m_tick uses the new IME.
  - di clears IME, ARM1 and ARM2 on the same m_tick.
  - reti sets IME=1 immediately.
  - ei while IME=1 has no effect.
- FSM IDLE -> DISPATCH:
  - Trigger: m_tick & instr_boundary & irq_pending & no halt_enter.
  - On entry: IME cleared and ARMx cleared; dispatch_active=1, dispatch_cycle=0.
- FSM DISPATCH:
  - dispatch_cycle increments on each m_tick.
  - On the m_tick from cycle 3 to cycle 4, IE&IF is re-sampled. This covers the PCH push overwriting IE.
    - If non-zero: the lowest set index n is latched, vector = VECTOR_BASE + 8n, and IF[n] is cleared.
    - If zero: vector = 8'h00 (cancelled dispatch) and IF is unchanged.
  - The m_tick at cycle 4 returns the FSM to IDLE with vector and dispatch_cycle cleared to 0.
- ei/di/reti during DISPATCH are ignored. The scheduler never issues them there.
- HALT: wake is purely combinational. halt_enter with IME=1 and a pending interrupt leaves dispatch to the next instr_boundary.
- Reset mid-dispatch: immediate return to the reset state; a partially cleared IF is not restored.

Optional Feature:
GB_IRQ_HALT_BUG_EN:
- Defined: halt_bug pulses for one clk on the m_tick where halt_enter=1, IME=0 and |(IE&IF)=1. The scheduler uses it to skip the next PC increment.
- Undefined: halt_bug is tied 0 and the detection logic is absent.

Test Plan:
- Reset, then read 0xFF0F -> 8'hE0. Read 0xFFFF -> 8'h00. irq_pending=0.
- IE=0x05, IF write 0x04, IME set via reti, then an instr_boundary m_tick -> dispatch_active for 5 m_ticks. vector=8'h50 in cycle 4. IF reads 8'hE0 afterwards. IME=0.
- ei on instr A, IE=IF=0x01 pending -> no dispatch at A's boundary. Dispatch starts at the boundary of instr B. vector=8'h40.
- ei followed by di before the next boundary -> IME stays 0 and no dispatch over 3 boundaries.
- During dispatch cycle 3, write IE=0x00 -> vector=8'h00 and IF bits unchanged. Repeat with IE changed 0x03 -> 0x02 while IF=0x03: vector=8'h48, IF ends 0x01.
- Same clk: IF write 0x00 and irq_src=5'b00010 -> IF reads 8'hE2. With GB_IRQ_HALT_BUG_EN: halt_enter, IME=0, IE=IF=0x02 -> halt_bug pulses once and wake=1.
